// File: rtl/sb_fifo_pkg.sv
// Shared types and helpers for the sideband TX packet FIFO.
// Pointers carry one extra wrap bit beyond the address.
package sb_fifo_pkg;

    localparam int SB_DATA_W_DEFAULT = 64;
    localparam int SB_DEPTH_DEFAULT  = 64;

    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } sb_fifo_entry_t;

    // Occupancy between two wrap-bit pointers of width w.
    function automatic logic [31:0] ptr_used(
        input logic [31:0] wr,
        input logic [31:0] rd,
        input int unsigned w
    );
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (wr - rd) & mask;
    endfunction

endpackage

// File: rtl/sb_fifo_ram.sv
// Simple dual-port storage with one write port and a registered read port.
// The array itself is not reset; only the read register is.
module sb_fifo_ram
    import sb_fifo_pkg::*;
#(
    parameter  int WIDTH = SB_DATA_W_DEFAULT + 1,
    parameter  int DEPTH = SB_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (i_re) begin
            rdata_d = mem[i_raddr];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/sb_tx_pkt_fifo.sv
// Packet-aware sideband TX FIFO: words become readable only once their
// packet is committed; an open packet can be aborted.
module sb_tx_pkt_fifo
    import sb_fifo_pkg::*;
#(
    parameter  int DATA_W       = SB_DATA_W_DEFAULT,
    parameter  int DEPTH        = SB_DEPTH_DEFAULT,
    parameter  int AFULL_THRESH = DEPTH - 2,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_write_enable,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_wr_last,
    input  logic              i_abort,
    input  logic              i_read_enable,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_rd_last,
    output logic              o_rd_valid,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_almost_full,
    output logic [ADDR_W:0]   o_free_count,
    output logic [ADDR_W:0]   o_pkt_count,
    output logic              o_overflow
);

    localparam int PW = ADDR_W + 1;

    logic [PW-1:0] wr_d, wr_q;
    logic [PW-1:0] cm_d, cm_q;
    logic [PW-1:0] rd_d, rd_q;
    logic [PW-1:0] pkt_d, pkt_q;
    logic          rd_valid_d, rd_valid_q;
    logic          ovf_d, ovf_q;

    logic [PW-1:0]    used;
    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;
    logic             commit;
    logic             rd_is_last;
    logic [DEPTH-1:0] last_mem;
    logic [DATA_W:0]  rdata;

    assign used  = PW'(ptr_used(32'(wr_q), 32'(rd_q), PW));
    assign full  = (wr_q[ADDR_W] != rd_q[ADDR_W]) &&
                   (wr_q[ADDR_W-1:0] == rd_q[ADDR_W-1:0]);
    assign empty = (cm_q == rd_q);

    assign wr_acc     = i_write_enable & ~full & ~i_abort;
    assign rd_acc     = i_read_enable & ~empty;
    assign commit     = wr_acc & i_wr_last;
    assign rd_is_last = last_mem[rd_q[ADDR_W-1:0]];

    // Last flags are mirrored here so the packet count can
    // drop on the same edge that pops a packet's final word.
    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            last_mem[wr_q[ADDR_W-1:0]] <= i_wr_last;
        end
    end

    always_comb begin
        wr_d       = wr_q;
        cm_d       = cm_q;
        rd_d       = rd_q;
        pkt_d      = pkt_q;
        rd_valid_d = rd_acc;
        ovf_d      = ovf_q;
        if (i_abort) begin
            wr_d = cm_q;
        end else if (wr_acc) begin
            wr_d = wr_q + 1'b1;
        end
        if (commit) begin
            cm_d = wr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_d = rd_q + 1'b1;
        end
        if (i_write_enable & full & ~i_abort) begin
            ovf_d = 1'b1;
        end
        unique case ({commit, rd_acc & rd_is_last})
            2'b10:   pkt_d = pkt_q + 1'b1;
            2'b01:   pkt_d = pkt_q - 1'b1;
            default: pkt_d = pkt_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q       <= '0;
            cm_q       <= '0;
            rd_q       <= '0;
            pkt_q      <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            cm_q       <= cm_d;
            rd_q       <= rd_d;
            pkt_q      <= pkt_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    sb_fifo_ram #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (wr_acc),
        .i_waddr (wr_q[ADDR_W-1:0]),
        .i_wdata ({i_wr_last, i_data_in}),
        .i_re    (rd_acc),
        .i_raddr (rd_q[ADDR_W-1:0]),
        .o_rdata (rdata)
    );

    assign o_data_out    = rdata[DATA_W-1:0];
    assign o_rd_last     = rdata[DATA_W];
    assign o_rd_valid    = rd_valid_q;
    assign o_empty       = empty;
    assign o_full        = full;
    assign o_almost_full = (used >= PW'(AFULL_THRESH));
    assign o_free_count  = PW'(DEPTH) - used;
    assign o_pkt_count   = pkt_q;
    assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_sb_tx_pkt_fifo.sv
// Scoreboard bench for sb_tx_pkt_fifo at DEPTH=8, AFULL_THRESH=6.
// Stimulus pushes expected words; a negedge monitor pops and compares.
module tb_sb_tx_pkt_fifo;
    import sb_fifo_pkg::*;

    localparam int DW = 64;
    localparam int D  = 8;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [DW-1:0] din;
    logic          wlast;
    logic          abort;
    logic          re;
    logic [DW-1:0] dout;
    logic          rlast;
    logic          rvalid;
    logic          empty;
    logic          full;
    logic          afull;
    logic [3:0]    free_cnt;
    logic [3:0]    pkt_cnt;
    logic          ovf;

    int vectors;
    int miscompares;
    int m_used;
    int m_avail;
    int m_pkts;
    int reads_issued;
    int reads_seen;

    sb_fifo_entry_t open_q[$];
    sb_fifo_entry_t sb_q[$];

    sb_tx_pkt_fifo #(
        .DATA_W       (DW),
        .DEPTH        (D),
        .AFULL_THRESH (6)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_write_enable (we),
        .i_data_in      (din),
        .i_wr_last      (wlast),
        .i_abort        (abort),
        .i_read_enable  (re),
        .o_data_out     (dout),
        .o_rd_last      (rlast),
        .o_rd_valid     (rvalid),
        .o_empty        (empty),
        .o_full         (full),
        .o_almost_full  (afull),
        .o_free_count   (free_cnt),
        .o_pkt_count    (pkt_cnt),
        .o_overflow     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle and advance the reference model on pre-edge state.
    task automatic op(input logic w, input logic [63:0] d,
                      input logic l, input logic ab, input logic r);
        bit mfull, mempty, aw, ar;
        sb_fifo_entry_t e;
        mfull  = (m_used == D);
        mempty = (m_avail == 0);
        aw     = w && !mfull && !ab;
        ar     = r && !mempty;
        if (ar) begin
            e = sb_q[sb_q.size() - m_avail];
            if (e.last) m_pkts--;
            m_avail--;
            m_used--;
            reads_issued++;
        end
        if (ab) begin
            m_used -= open_q.size();
            open_q.delete();
        end
        if (aw) begin
            e.last = l;
            e.data = d;
            open_q.push_back(e);
            m_used++;
            if (l) begin
                foreach (open_q[i]) sb_q.push_back(open_q[i]);
                m_avail += open_q.size();
                open_q.delete();
                m_pkts++;
            end
        end
        we    = w;
        din   = d;
        wlast = l;
        abort = ab;
        re    = r;
        @(posedge clk);
        #1;
        we    = 1'b0;
        wlast = 1'b0;
        abort = 1'b0;
        re    = 1'b0;
    endtask

    task automatic wr(input logic [63:0] d, input logic l);
        op(1'b1, d, l, 1'b0, 1'b0);
    endtask

    task automatic rd();
        op(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        op(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            sb_fifo_entry_t e;
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_word: got %0h last %0b expected none",
                         dout, rlast);
            end else begin
                e = sb_q.pop_front();
                if ({rlast, dout} !== {e.last, e.data}) begin
                    miscompares++;
                    $display("FAIL rd_word: got %0h last %0b expected %0h last %0b",
                             dout, rlast, e.data, e.last);
                end
            end
            reads_seen++;
        end
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        m_used = 0;
        m_avail = 0;
        m_pkts = 0;
        reads_issued = 0;
        reads_seen = 0;
        rst_n = 1'b0;
        we = 1'b0;
        din = '0;
        wlast = 1'b0;
        abort = 1'b0;
        re = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_afull", 64'(afull), 64'd0);
        chk("rst_free", 64'(free_cnt), 64'd8);
        chk("rst_pkt", 64'(pkt_cnt), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_dout", dout, 64'd0);

        wr(64'hA1, 1'b0);
        wr(64'hA2, 1'b0);
        chk("open_empty", 64'(empty), 64'd1);
        chk("open_free", 64'(free_cnt), 64'd6);
        wr(64'hA3, 1'b1);
        chk("commit_empty", 64'(empty), 64'd0);
        chk("commit_pkt", 64'(pkt_cnt), 64'd1);
        rd();
        rd();
        rd();
        chk("drain_pkt", 64'(pkt_cnt), 64'd0);
        idle();
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_free", 64'(free_cnt), 64'd8);

        wr(64'hC1, 1'b0);
        wr(64'hC2, 1'b0);
        wr(64'hC3, 1'b0);
        chk("pre_abort_free", 64'(free_cnt), 64'd5);
        op(1'b1, 64'hFF, 1'b0, 1'b1, 1'b0);
        chk("abort_free", 64'(free_cnt), 64'd8);
        chk("abort_empty", 64'(empty), 64'd1);
        chk("abort_ovf", 64'(ovf), 64'd0);
        wr(64'hB0, 1'b1);
        rd();
        idle();

        for (int i = 0; i < 8; i++) begin
            wr(64'hD0 + 64'(i), (i == 3) || (i == 7));
        end
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_free", 64'(free_cnt), 64'd0);
        chk("fill_pkt", 64'(pkt_cnt), 64'd2);
        chk("fill_afull", 64'(afull), 64'd1);
        wr(64'hEE, 1'b1);
        chk("ovf_set", 64'(ovf), 64'd1);
        chk("ovf_full", 64'(full), 64'd1);
        op(1'b1, 64'h99, 1'b1, 1'b0, 1'b1);
        chk("rw_full_free", 64'(free_cnt), 64'd1);
        chk("rw_full_full", 64'(full), 64'd0);
        chk("rw_full_pkt", 64'(pkt_cnt), 64'd2);
        for (int i = 0; i < 7; i++) rd();
        chk("full_drain_pkt", 64'(pkt_cnt), 64'd0);
        chk("full_drain_empty", 64'(empty), 64'd1);
        chk("ovf_sticky", 64'(ovf), 64'd1);
        idle();

        for (int i = 0; i < 5; i++) wr(64'hF1 + 64'(i), 1'b0);
        chk("af_5", 64'(afull), 64'd0);
        wr(64'hF6, 1'b1);
        chk("af_6", 64'(afull), 64'd1);
        rd();
        chk("af_after_rd", 64'(afull), 64'd0);
        for (int i = 0; i < 5; i++) rd();
        idle();

        op(1'b1, 64'h61, 1'b1, 1'b0, 1'b1);
        chk("cm_rd_empty_pkt", 64'(pkt_cnt), 64'd1);
        chk("cm_rd_empty_empty", 64'(empty), 64'd0);
        op(1'b1, 64'h71, 1'b1, 1'b0, 1'b1);
        chk("cm_rd_last_pkt", 64'(pkt_cnt), 64'd1);
        rd();
        chk("cm_rd_done_pkt", 64'(pkt_cnt), 64'd0);
        idle();
        chk("idle_rvalid", 64'(rvalid), 64'd0);
        chk("hold_dout", dout, 64'h71);
        rd();
        chk("rd_empty_dout", dout, 64'h71);
        chk("rd_empty_last", 64'(rlast), 64'd1);
        chk("rd_empty_rvalid", 64'(rvalid), 64'd0);

        for (int c = 0; c < 1000; c++) begin
            op(1'($urandom_range(0, 1)), {$urandom, $urandom},
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
               1'($urandom_range(0, 1)));
            chk("rand_free", 64'(free_cnt), 64'(D - m_used));
            chk("rand_pkt", 64'(pkt_cnt), 64'(m_pkts));
            chk("rand_empty", 64'(empty), 64'(m_avail == 0));
            chk("rand_full", 64'(full), 64'(m_used == D));
        end

        for (int g = 0; g < 20 && m_avail > 0; g++) rd();
        op(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("end_sb_empty", 64'(sb_q.size()), 64'd0);
        chk("end_reads", 64'(reads_seen), 64'(reads_issued));
        chk("end_free", 64'(free_cnt), 64'd8);
        chk("end_empty", 64'(empty), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
